// File: rtl/char_wr_arbiter.sv
// Write-port owner for the 80x60 VGA character buffer: round-robin arbitration
// between two requesters plus a full-screen clear sequencer.
`timescale 1ns/1ps

module char_wr_arbiter #(
   parameter int          COLS      = 80,
   parameter int          ROWS      = 60,
   parameter int          ADDR_W    = 13,
   parameter logic [7:0]  FILL_CHAR = 8'h20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [7:0]        a_data,
   output logic              a_gnt,
   input  logic              b_req,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [7:0]        b_data,
   output logic              b_gnt,
   output logic [ADDR_W-1:0] buf_addr,
   output logic [7:0]        buf_data,
   output logic              buf_wr_en,
   output logic              oor_err
);

   typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_e;

   localparam logic [ADDR_W-1:0] CELLS     = ADDR_W'(COLS * ROWS);
   localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              clr_last_q, clr_last_d;
   logic              clr_pend_q, clr_pend_d;
   logic              ptr_q, ptr_d;           // 1 = A won last, so B is favoured next
   logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
   logic [7:0]        buf_data_q, buf_data_d;
   logic              wr_en_q, wr_en_d;
   logic              a_gnt_q, a_gnt_d;
   logic              b_gnt_q, b_gnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              oor_q, oor_d;

   logic              grant_a, grant_b;
   logic [ADDR_W-1:0] win_addr;
   logic [7:0]        win_data;

   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      state_d    = state_q;
      cnt_d      = cnt_q;
      clr_last_d = clr_last_q;
      clr_pend_d = clr_pend_q;
      ptr_d      = ptr_q;
      buf_addr_d = buf_addr_q;
      buf_data_d = buf_data_q;
      wr_en_d    = 1'b0;
      a_gnt_d    = 1'b0;
      b_gnt_d    = 1'b0;
      done_d     = 1'b0;
      oor_d      = oor_q;
      grant_a    = 1'b0;
      grant_b    = 1'b0;
      win_addr   = a_addr;
      win_data   = a_data;

      case (state_q)
         IDLE: begin
            if (clr_pend_q) begin
               state_d    = CLEAR;
               cnt_d      = '0;
               clr_last_d = 1'b0;
               clr_pend_d = 1'b0;
            end else begin
               if (a_req && b_req) begin
                  grant_a = ~ptr_q;
                  grant_b = ptr_q;
               end else begin
                  grant_a = a_req;
                  grant_b = b_req;
               end
               if (grant_b) begin
                  win_addr = b_addr;
                  win_data = b_data;
               end
               if (grant_a || grant_b) begin
                  state_d = WRITE;
                  a_gnt_d = grant_a;
                  b_gnt_d = grant_b;
                  ptr_d   = grant_a;
                  // Out-of-range writes are still granted so the requester never stalls.
                  if (win_addr < CELLS) begin
                     wr_en_d    = 1'b1;
                     buf_addr_d = win_addr;
                     buf_data_d = win_data;
                  end else begin
                     oor_d = 1'b1;
                  end
               end
            end
         end
         WRITE: state_d = IDLE;
         CLEAR: begin
            if (clr_last_q) begin
               state_d    = IDLE;
               done_d     = 1'b1;
               clr_last_d = 1'b0;
            end else begin
               wr_en_d    = 1'b1;
               buf_addr_d = cnt_q;
               buf_data_d = FILL_CHAR;
               if (cnt_q == LAST_CELL) clr_last_d = 1'b1;
               else                    cnt_d      = cnt_q + ADDR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (clr_req && (state_q != CLEAR)) clr_pend_d = 1'b1;
      busy_d = clr_pend_d || (state_d == CLEAR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         clr_last_q <= 1'b0;
         clr_pend_q <= 1'b0;
         ptr_q      <= 1'b0;
         buf_addr_q <= '0;
         buf_data_q <= '0;
         wr_en_q    <= 1'b0;
         a_gnt_q    <= 1'b0;
         b_gnt_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         oor_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         clr_last_q <= clr_last_d;
         clr_pend_q <= clr_pend_d;
         ptr_q      <= ptr_d;
         buf_addr_q <= buf_addr_d;
         buf_data_q <= buf_data_d;
         wr_en_q    <= wr_en_d;
         a_gnt_q    <= a_gnt_d;
         b_gnt_q    <= b_gnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         oor_q      <= oor_d;
      end
   end

   assign clr_busy  = busy_q;
   assign clr_done  = done_q;
   assign a_gnt     = a_gnt_q;
   assign b_gnt     = b_gnt_q;
   assign buf_addr  = buf_addr_q;
   assign buf_data  = buf_data_q;
   assign buf_wr_en = wr_en_q;
   assign oor_err   = oor_q;

endmodule

// File: tb/tb_char_wr_arbiter.sv
// Randomized bench for char_wr_arbiter against a transaction-level model of
// round-robin arbitration, out-of-range handling and the clear sweep.
`timescale 1ns/1ps

module tb_char_wr_arbiter;

   localparam int CELLS = 80 * 60;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr_req = 1'b0;
   logic        clr_busy, clr_done;
   logic        a_req = 1'b0, b_req = 1'b0;
   logic [12:0] a_addr = '0, b_addr = '0;
   logic [7:0]  a_data = '0, b_data = '0;
   logic        a_gnt, b_gnt;
   logic [12:0] buf_addr;
   logic [7:0]  buf_data;
   logic        buf_wr_en, oor_err;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: who won last contention, sticky error, last written cell.
   bit          last_a;
   bit          exp_oor;
   logic [12:0] exp_addr;
   logic [7:0]  exp_data;

   char_wr_arbiter dut (
      .clk(clk), .rst(rst),
      .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
      .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
      .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
      .buf_addr(buf_addr), .buf_data(buf_data), .buf_wr_en(buf_wr_en),
      .oor_err(oor_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [12:0] rand_addr(input bit allow_oor);
      if (allow_oor && ($urandom % 4 == 0)) return 13'($urandom_range(8191, CELLS));
      return 13'($urandom_range(CELLS - 1, 0));
   endfunction

   task automatic model_reset();
      last_a = 1'b0; exp_oor = 1'b0; exp_addr = '0; exp_data = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1; clr_req = 1'b0; a_req = 1'b0; b_req = 1'b0;
      tick(); tick();
      rst = 1'b0;
      model_reset();
   endtask

   task automatic check_all_zero(input string tag);
      n_checks++;
      if ({clr_busy, clr_done, a_gnt, b_gnt, buf_wr_en, oor_err} !== 6'b0) begin
         n_fail++;
         $display("FAIL %s_flags: got %b expected 000000", tag,
                  {clr_busy, clr_done, a_gnt, b_gnt, buf_wr_en, oor_err});
      end
      n_checks++;
      if ({buf_addr, buf_data} !== 21'h0) begin
         n_fail++;
         $display("FAIL %s_bus: got addr %h data %h expected 0/0", tag, buf_addr, buf_data);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; a_req = 1'b1; b_req = 1'b1; clr_req = 1'b1;
      a_addr = rand_addr(0); b_addr = rand_addr(0);
      tick(); tick();
      check_all_zero("reset");
      rst = 1'b0; a_req = 1'b0; b_req = 1'b0; clr_req = 1'b0;
      model_reset();
   endtask

   task automatic test_single_write();
      a_req = 1'b1; a_addr = 13'h0051; a_data = 8'h41;
      tick();
      n_checks++;
      if ({a_gnt, b_gnt, buf_wr_en} !== 3'b101) begin
         n_fail++; $display("FAIL single_gnt: got a/b/wr %b expected 101", {a_gnt, b_gnt, buf_wr_en});
      end
      n_checks++;
      if (buf_addr !== 13'h0051 || buf_data !== 8'h41) begin
         n_fail++; $display("FAIL single_bus: got %h/%h expected 0051/41", buf_addr, buf_data);
      end
      last_a = 1'b1; exp_addr = 13'h0051; exp_data = 8'h41;
      tick();  // request still held during the grant cycle
      n_checks++;
      if ({a_gnt, buf_wr_en, buf_addr} !== {2'b00, 13'h0051}) begin
         n_fail++; $display("FAIL single_no_regrant: got gnt %b wr %b addr %h", a_gnt, buf_wr_en, buf_addr);
      end
      a_req = 1'b0;
      tick();
      n_checks++;
      if ({a_gnt, buf_wr_en} !== 2'b00) begin
         n_fail++; $display("FAIL single_idle: got gnt %b wr %b expected 00", a_gnt, buf_wr_en);
      end
   endtask

   task automatic test_alternate();
      int  writes;
      bit  exp_a, exp_b;
      do_reset();
      writes = 0;
      a_req = 1'b1; a_addr = rand_addr(0); a_data = 8'($urandom);
      b_req = 1'b1; b_addr = rand_addr(0); b_data = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
         // Both held: one grant every other cycle, alternating from A.
         exp_a = (i % 2 == 0) && !last_a;
         exp_b = (i % 2 == 0) &&  last_a;
         if (exp_a) begin exp_addr = a_addr; exp_data = a_data; end
         if (exp_b) begin exp_addr = b_addr; exp_data = b_data; end
         tick();
         n_checks++;
         if ({a_gnt, b_gnt, buf_wr_en} !== {exp_a, exp_b, exp_a | exp_b}) begin
            n_fail++;
            $display("FAIL alt_gnt[%0d]: got a/b/wr %b expected %b", i,
                     {a_gnt, b_gnt, buf_wr_en}, {exp_a, exp_b, exp_a | exp_b});
         end
         n_checks++;
         if (buf_addr !== exp_addr || buf_data !== exp_data) begin
            n_fail++;
            $display("FAIL alt_bus[%0d]: got %h/%h expected %h/%h", i, buf_addr, buf_data, exp_addr, exp_data);
         end
         if (buf_wr_en === 1'b1) writes++;
         if (exp_a) begin last_a = 1'b1; a_addr = rand_addr(0); a_data = 8'($urandom); end
         if (exp_b) begin last_a = 1'b0; b_addr = rand_addr(0); b_data = 8'($urandom); end
      end
      a_req = 1'b0; b_req = 1'b0;
      n_checks++;
      if (writes != 4) begin
         n_fail++; $display("FAIL alt_count: got %0d writes expected 4", writes);
      end
      tick();
   endtask

   task automatic test_oor();
      b_req = 1'b1; b_addr = 13'd4800; b_data = 8'h58;
      tick();
      n_checks++;
      if ({b_gnt, buf_wr_en, oor_err} !== 3'b101) begin
         n_fail++; $display("FAIL oor_first: got gnt/wr/oor %b expected 101", {b_gnt, buf_wr_en, oor_err});
      end
      n_checks++;
      if (buf_addr !== exp_addr || buf_data !== exp_data) begin
         n_fail++; $display("FAIL oor_hold: got %h/%h expected %h/%h", buf_addr, buf_data, exp_addr, exp_data);
      end
      b_req = 1'b0; last_a = 1'b0; exp_oor = 1'b1;
      tick(); tick(); tick();
      n_checks++;
      if (oor_err !== 1'b1) begin
         n_fail++; $display("FAIL oor_sticky: got %b expected 1", oor_err);
      end
      a_req = 1'b1; a_addr = rand_addr(0); a_data = 8'($urandom);
      tick();
      n_checks++;
      if ({a_gnt, buf_wr_en, oor_err, buf_addr, buf_data} !== {3'b111, a_addr, a_data}) begin
         n_fail++; $display("FAIL oor_then_valid: got gnt/wr/oor %b addr %h", {a_gnt, buf_wr_en, oor_err}, buf_addr);
      end
      a_req = 1'b0;
      do_reset();
      n_checks++;
      if (oor_err !== 1'b0) begin
         n_fail++; $display("FAIL oor_reset: got %b expected 0", oor_err);
      end
   endtask

   task automatic test_random();
      bit cooldown, exp_a, exp_b, exp_wr;
      do_reset();
      cooldown = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (!a_req && ($urandom % 3 == 0)) begin a_req = 1'b1; a_addr = rand_addr(1); a_data = 8'($urandom); end
         if (!b_req && ($urandom % 3 == 0)) begin b_req = 1'b1; b_addr = rand_addr(1); b_data = 8'($urandom); end
         exp_a = 1'b0; exp_b = 1'b0; exp_wr = 1'b0;
         if (!cooldown) begin
            if (a_req && b_req) begin exp_a = !last_a; exp_b = last_a; end
            else begin exp_a = a_req; exp_b = b_req; end
         end
         if (exp_a) begin
            if (a_addr < CELLS) begin exp_wr = 1'b1; exp_addr = a_addr; exp_data = a_data; end
            else exp_oor = 1'b1;
         end
         if (exp_b) begin
            if (b_addr < CELLS) begin exp_wr = 1'b1; exp_addr = b_addr; exp_data = b_data; end
            else exp_oor = 1'b1;
         end
         tick();
         n_checks++;
         if ({a_gnt, b_gnt, buf_wr_en, oor_err} !== {exp_a, exp_b, exp_wr, exp_oor}) begin
            n_fail++;
            $display("FAIL rand_ctl[%0d]: got a/b/wr/oor %b expected %b", i,
                     {a_gnt, b_gnt, buf_wr_en, oor_err}, {exp_a, exp_b, exp_wr, exp_oor});
         end
         n_checks++;
         if (buf_addr !== exp_addr || buf_data !== exp_data) begin
            n_fail++;
            $display("FAIL rand_bus[%0d]: got %h/%h expected %h/%h", i, buf_addr, buf_data, exp_addr, exp_data);
         end
         cooldown = exp_a | exp_b;
         if (exp_a) begin last_a = 1'b1; a_req = 1'b0; end
         if (exp_b) begin last_a = 1'b0; b_req = 1'b0; end
      end
      a_req = 1'b0; b_req = 1'b0;
      tick(); tick();
   endtask

   task automatic test_clear();
      int idx;
      bit started, done_seen;
      logic [12:0] pend_addr;
      logic [7:0]  pend_data;
      idx = 0; started = 1'b0; done_seen = 1'b0;
      pend_addr = rand_addr(0); pend_data = 8'($urandom);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      n_checks++;
      if ({clr_busy, buf_wr_en} !== 2'b10) begin
         n_fail++; $display("FAIL clr_busy_rise: got busy/wr %b expected 10", {clr_busy, buf_wr_en});
      end
      for (int cyc = 0; cyc < CELLS + 20 && !done_seen; cyc++) begin
         tick();
         n_checks++;
         if (a_gnt !== 1'b0) begin
            n_fail++; $display("FAIL clr_stall: got a_gnt %b at write %0d expected 0", a_gnt, idx);
         end
         if (clr_done === 1'b1) begin
            done_seen = 1'b1;
            n_checks++;
            if (idx != CELLS || buf_wr_en !== 1'b0 || clr_busy !== 1'b0) begin
               n_fail++;
               $display("FAIL clr_done_state: got writes %0d wr %b busy %b expected %0d/0/0",
                        idx, buf_wr_en, clr_busy, CELLS);
            end
         end else begin
            n_checks++;
            if (clr_busy !== 1'b1) begin
               n_fail++; $display("FAIL clr_busy_hold: got %b at write %0d expected 1", clr_busy, idx);
            end
            if (buf_wr_en === 1'b1) begin
               started = 1'b1;
               n_checks++;
               if (buf_addr !== 13'(idx) || buf_data !== 8'h20) begin
                  n_fail++;
                  $display("FAIL clr_write: got %h/%h expected %h/20", buf_addr, buf_data, 13'(idx));
               end
               idx++;
            end else if (started) begin
               n_checks++; n_fail++;
               $display("FAIL clr_gap: got wr_en 0 after %0d writes expected 1", idx);
            end
            if (idx == 1000 && !a_req) begin a_req = 1'b1; a_addr = pend_addr; a_data = pend_data; end
         end
      end
      n_checks++;
      if (!done_seen) begin
         n_fail++; $display("FAIL clr_timeout: got %0d writes and no clr_done expected %0d", idx, CELLS);
      end
      tick();
      n_checks++;
      if ({a_gnt, buf_wr_en, clr_done, buf_addr, buf_data} !== {3'b110, pend_addr, pend_data}) begin
         n_fail++;
         $display("FAIL clr_after_grant: got gnt/wr/done %b addr %h expected 110 %h",
                  {a_gnt, buf_wr_en, clr_done}, buf_addr, pend_addr);
      end
      a_req = 1'b0; last_a = 1'b1; exp_addr = pend_addr; exp_data = pend_data;
      tick();
   endtask

   task automatic test_reset_mid_clear();
      bit hit;
      hit = 1'b0;
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int cyc = 0; cyc < 2100 && !hit; cyc++) begin
         tick();
         if (buf_wr_en === 1'b1 && buf_addr === 13'd2000) hit = 1'b1;
      end
      n_checks++;
      if (!hit) begin
         n_fail++; $display("FAIL midclr_reach: got no write at 2000 expected one within 2100 cycles");
      end
      rst = 1'b1;
      tick();
      check_all_zero("midclr_reset");
      rst = 1'b0;
      model_reset();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      hit = 1'b0;
      for (int cyc = 0; cyc < 10 && !hit; cyc++) begin
         tick();
         if (buf_wr_en === 1'b1) hit = 1'b1;
      end
      n_checks++;
      if (!hit || buf_addr !== 13'd0 || buf_data !== 8'h20) begin
         n_fail++; $display("FAIL midclr_restart: got seen %b addr %h data %h expected 1 0000 20", hit, buf_addr, buf_data);
      end
      do_reset();
   endtask

   task automatic test_clear_coincident();
      int idx, dones;
      bit pulsed;
      idx = 0; dones = 0; pulsed = 1'b0;
      a_req = 1'b1; a_addr = rand_addr(0); a_data = 8'($urandom);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0; a_req = 1'b0;
      n_checks++;
      if ({a_gnt, buf_wr_en, clr_busy, buf_addr, buf_data} !== {3'b111, a_addr, a_data}) begin
         n_fail++;
         $display("FAIL coinc_a_first: got gnt/wr/busy %b addr %h expected 111 %h",
                  {a_gnt, buf_wr_en, clr_busy}, buf_addr, a_addr);
      end
      for (int cyc = 0; cyc < CELLS + 40; cyc++) begin
         tick();
         clr_req = 1'b0;
         if (clr_done === 1'b1) dones++;
         if (buf_wr_en === 1'b1) begin
            n_checks++;
            if (buf_addr !== 13'(idx) || buf_data !== 8'h20) begin
               n_fail++; $display("FAIL coinc_write: got %h/%h expected %h/20", buf_addr, buf_data, 13'(idx));
            end
            idx++;
         end
         if (idx == 100 && !pulsed) begin clr_req = 1'b1; pulsed = 1'b1; end
      end
      n_checks++;
      if (dones != 1 || idx != CELLS) begin
         n_fail++; $display("FAIL coinc_once: got %0d done pulses %0d writes expected 1/%0d", dones, idx, CELLS);
      end
      n_checks++;
      if ({clr_busy, buf_wr_en, a_gnt, b_gnt} !== 4'b0000) begin
         n_fail++; $display("FAIL coinc_idle: got busy/wr/gnts %b expected 0000", {clr_busy, buf_wr_en, a_gnt, b_gnt});
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_write();
      test_alternate();
      test_oor();
      test_random();
      test_clear();
      test_reset_mid_clear();
      test_clear_coincident();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/char_wr_arbiter.md
Name: char_wr_arbiter

Overview:
- Owns the single write port of the VGA character buffer: 80x60 cells, 13-bit linear address, 8-bit ASCII.
- Shares the port between two requesters, A and B. Requester A is the UART terminal sequencer; requester B is a status/overlay writer.
- Contains a clear-screen sequencer that sweeps every cell with a fill character.
- Sits between the requesters and the buffer write inputs (address, data, write enable).

Parameters:
- COLS, 80, characters per row
- ROWS, 60, rows per screen
- ADDR_W, 13, buffer address width; must satisfy 2^ADDR_W >= COLS*ROWS
- FILL_CHAR, 8'h20, character written during clear

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clr_req  in  1  one-cycle pulse requesting a full-screen clear
- clr_busy  out  1  high while a clear is pending or executing
- clr_done  out  1  one-cycle pulse after the last clear write
- a_req  in  1  requester A write request; held until a_gnt
- a_addr  in  ADDR_W  requester A cell address
- a_data  in  8  requester A character
- a_gnt  out  1  one-cycle grant/accept to A
- b_req  in  1  requester B write request; held until b_gnt
- b_addr  in  ADDR_W  requester B cell address
- b_data  in  8  requester B character
- b_gnt  out  1  one-cycle grant/accept to B
- buf_addr  out  ADDR_W  buffer write address (registered)
- buf_data  out  8  buffer write data (registered)
- buf_wr_en  out  1  buffer write enable, one cycle per write
- oor_err  out  1  sticky flag: an out-of-range address was dropped

Behaviour:

Reset:
- While rst is sampled high at a clock edge, all outputs go to 0.
- State goes to IDLE; clear counter, clear-pending bit and round-robin pointer are zeroed.
- Pointer = 0 favours A.
- Reset overrides everything, including mid-clear; a partially cleared screen is left as is.

Clear-request latching:
- clr_req sampled high in any state other than CLEAR sets clr_pend.
- clr_req during CLEAR is ignored; no restart, no queueing.
- clr_busy = clr_pend OR (state == CLEAR), registered. It rises the cycle after the clr_req edge.

State machine, states IDLE, WRITE, CLEAR:

IDLE, evaluated in priority order:
1. clr_pend: go to CLEAR; counter = 0; clr_pend cleared.
2. a_req and b_req both high: grant the requester not named by the pointer.
3. Exactly one request high: grant that requester.
4. Otherwise stay in IDLE.

On a grant from IDLE:
- Register the winner's addr/data into buf_addr/buf_data.
- Next cycle: go to WRITE, winner's gnt = 1, pointer = winner.
- buf_wr_en = 1 only if addr < COLS*ROWS. Otherwise buf_wr_en = 0 and oor_err is set; the requester is still granted so it never deadlocks.

WRITE:
- Lasts exactly one cycle, then returns to IDLE.
- gnt and buf_wr_en are high for this cycle only.
- No requester is re-evaluated in this cycle, so a requester still holding req while seeing gnt is not double-granted.
- Maximum throughput: one write per 2 cycles.
- Latency: req sampled at edge t, write and gnt visible in cycle t+1.

CLEAR:
- buf_wr_en = 1 every cycle, buf_data = FILL_CHAR, buf_addr = counter.
- Counter runs 0 .. COLS*ROWS-1 = 4799, so there are 4800 consecutive write cycles.
- After the write at address 4799: next cycle is IDLE, buf_wr_en = 0, clr_done = 1 for one cycle, clr_busy = 0.
- a_req/b_req are stalled (no gnt) for the entire clear; requests are serviced afterwards with normal arbitration.

Simultaneous events:
- clr_req arriving the same cycle a grant is issued: the grant completes (WRITE), then clear runs from the next IDLE.
- A request pending while clr_pend is set waits behind the clear.

Widths:
- Compare against COLS*ROWS computed as an ADDR_W-wide constant.
- The counter is ADDR_W bits and never wraps past COLS*ROWS-1.

Outputs:
- All outputs registered; no combinational path from inputs to outputs.
- buf_addr/buf_data hold their last value when buf_wr_en = 0.

Test Plan:
- Reset, then a_req with a_addr=0x0051, a_data=0x41 held: next cycle a_gnt=1, buf_wr_en=1, buf_addr=0x0051, buf_data=0x41; a_req held one extra cycle causes no second grant.
- a_req and b_req held continuously from reset: grants alternate B? No — first grant A (pointer=0 favours A), then B, A, B; each write 2 cycles apart; exactly 4 writes in 8 cycles.
- b_req with b_addr=4800, b_data=0x58: b_gnt=1, buf_wr_en=0, oor_err=1 and stays 1 until rst.
- clr_req pulse while idle: clr_busy rises the next cycle; then 4800 writes of 0x20 at addresses 0..4799, each address written once, in order; clr_done pulses once; a_req raised mid-clear is granted only after clr_done.
- rst asserted at clear write 2000: all outputs 0 next cycle, state IDLE; a following clr_req restarts from address 0.
- clr_req coincident with an a_req grant: the A write completes first, then the clear starts; a second clr_req during CLEAR produces no extra clear (exactly one clr_done).
